// File: rtl/ssp_tx_fifo_gen2_if.sv
// Bus bundle for ssp_tx_fifo_gen2: APB-style write port plus the SSP transmit pins.
// Optional SSP_TX_LEVEL_EN adds the FIFO level outputs TXLEVEL and SSPTXHALF.
interface ssp_tx_fifo_gen2_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              PSEL;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              SSPOE_B;
  logic              SSPTXD;
  logic              SSPCLKOUT;
  logic              SSPFSSOUT;
  logic              SSPTXINTR;

`ifdef SSP_TX_LEVEL_EN
  logic [CNT_W-1:0]  TXLEVEL;
  logic              SSPTXHALF;

  modport master (
    output PSEL, PWRITE, PWDATA,
    input  SSPOE_B, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPTXINTR, TXLEVEL, SSPTXHALF
  );
  modport slave (
    input  PSEL, PWRITE, PWDATA,
    output SSPOE_B, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPTXINTR, TXLEVEL, SSPTXHALF
  );
`else
  modport master (
    output PSEL, PWRITE, PWDATA,
    input  SSPOE_B, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPTXINTR
  );
  modport slave (
    input  PSEL, PWRITE, PWDATA,
    output SSPOE_B, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPTXINTR
  );
`endif
endinterface

// File: rtl/ssp_tx_fifo_gen2.sv
// SSP transmit path: DEPTH-entry write FIFO feeding an MSB-first framed serialiser at PCLK/2.
// Optional SSP_TX_LEVEL_EN drives TXLEVEL (FIFO count) and SSPTXHALF (count <= DEPTH/2).
module ssp_tx_fifo_gen2 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic               PCLK,
  input  logic               CLEAR_B,
  ssp_tx_fifo_gen2_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_SHIFT,
    ST_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              sclk_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              intr_q;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              txd_q, txd_d;
  logic              fss_q, fss_d;
  logic              oe_b_q, oe_b_d;
  logic              r_edge, f_edge;
  logic              full, push, pop;

  // sclk_q is the current SSPCLKOUT level, so the edge about to happen flips it.
  assign r_edge = ~sclk_q;
  assign f_edge = sclk_q;
  assign full   = (count_q == FULL_CNT);
  assign push   = bus.PSEL & bus.PWRITE & ~full;

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    fss_d     = fss_q;
    oe_b_d    = oe_b_q;
    pop       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (f_edge && count_q != '0) begin
          pop       = 1'b1;
          sh_d      = mem_q[rptr_q];
          bit_cnt_d = '0;
          fss_d     = 1'b1;
          oe_b_d    = 1'b0;
          state_d   = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (r_edge) begin
          txd_d     = sh_q[DATA_W-1];
          sh_d      = {sh_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
          fss_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_edge) begin
          if (bit_cnt_q != LAST_BIT) begin
            txd_d     = sh_q[DATA_W-1];
            sh_d      = {sh_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else if (bit_cnt_q == LAST_BIT) begin
          // Chaining the next word here keeps SSPOE_B low with no idle gap.
          if (count_q != '0) begin
            pop       = 1'b1;
            sh_d      = mem_q[rptr_q];
            bit_cnt_d = '0;
            fss_d     = 1'b1;
            state_d   = ST_FRAME;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (f_edge) begin
          oe_b_d  = 1'b1;
          txd_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q   <= ST_IDLE;
      sclk_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      intr_q    <= 1'b0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b0;
      fss_q     <= 1'b0;
      oe_b_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sclk_q    <= ~sclk_q;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      intr_q    <= (count_d == FULL_CNT);
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      fss_q     <= fss_d;
      oe_b_q    <= oe_b_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and count define which entries are valid.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wptr_q] <= bus.PWDATA;
    end
  end

  assign bus.SSPOE_B   = oe_b_q;
  assign bus.SSPTXD    = txd_q;
  assign bus.SSPCLKOUT = sclk_q;
  assign bus.SSPFSSOUT = fss_q;
  assign bus.SSPTXINTR = intr_q;

`ifdef SSP_TX_LEVEL_EN
  logic half_q;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      half_q <= 1'b1;
    end else begin
      half_q <= (count_d <= CNT_W'(DEPTH / 2));
    end
  end

  assign bus.TXLEVEL   = count_q;
  assign bus.SSPTXHALF = half_q;
`endif

endmodule
